// File: rtl/store_ctrl.sv
// store_ctrl: store-path write sequencer with lane shifting and byte enables.
// Define STORE_MISALIGN_SPLIT_EN to split cross-word stores into two writes.
module store_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_done,
  output logic              misalign_err,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be
);

`ifdef STORE_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, SEND_LO, SEND_HI
  } state_t;

  state_t state, nxt;

  logic              acc, nost, split;
  logic              reject, go;
  logic [3:0]        mask;
  logic [31:0]       dm;
  logic [7:0]        be8;
  logic [63:0]       d64;
  logic [ADDR_W-1:0] lo_addr, hi_addr_c;
  logic [ADDR_W-1:0] hi_addr;
  logic [31:0]       hi_data;
  logic [3:0]        hi_be;
  logic              hi_pend;
  logic              done_q, err_q;

  always_comb begin
    mask = 4'b0000;
    dm   = 32'h0;
    unique case (1'b1)
      st_type == 2'b00: begin
        mask = 4'b0001;
        dm   = {24'h0, st_data[7:0]};
      end
      st_type == 2'b01: begin
        mask = 4'b0011;
        dm   = {16'h0, st_data[15:0]};
      end
      st_type == 2'b10: begin
        mask = 4'b1111;
        dm   = st_data;
      end
      st_type == 2'b11: begin
        mask = 4'b0000;
        dm   = 32'h0;
      end
    endcase
  end

  assign be8       = {4'b0000, mask} << st_addr[1:0];
  assign d64       = {32'h0, dm} << {st_addr[1:0], 3'b000};
  assign lo_addr   = {st_addr[ADDR_W-1:2], 2'b00};
  assign hi_addr_c = lo_addr + ADDR_W'(4);
  assign split     = |be8[7:4];
  assign nost      = (st_type == 2'b11);
  assign reject    = split & ~SPLIT_EN;
  assign acc       = st_valid & st_ready;
  assign go        = acc & ~nost & ~reject;

  assign st_ready     = (state == IDLE);
  assign mem_req      = (state == SEND_LO) | (state == SEND_HI);
  assign st_done      = done_q;
  assign misalign_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (go) nxt = SEND_LO;
      SEND_LO: if (mem_ack) nxt = hi_pend ? SEND_HI : IDLE;
      SEND_HI: if (mem_ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Low half goes out first; the high half waits in hi_* until the first ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
      hi_addr   <= '0;
      hi_data   <= 32'h0;
      hi_be     <= 4'b0000;
      hi_pend   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: if (acc) begin
          if (nost | reject) begin
            done_q <= 1'b1;
            err_q  <= reject;
          end else begin
            mem_addr  <= lo_addr;
            mem_wdata <= d64[31:0];
            mem_be    <= be8[3:0];
            hi_addr   <= hi_addr_c;
            hi_data   <= d64[63:32];
            hi_be     <= be8[7:4];
            hi_pend   <= split;
          end
        end
        SEND_LO: if (mem_ack) begin
          if (hi_pend) begin
            mem_addr  <= hi_addr;
            mem_wdata <= hi_data;
            mem_be    <= hi_be;
            hi_pend   <= 1'b0;
          end else begin
            mem_be <= 4'b0000;
            done_q <= 1'b1;
          end
        end
        SEND_HI: if (mem_ack) begin
          mem_be <= 4'b0000;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_ctrl.sv
// tb_store_ctrl: directed table, random stores vs byte-level model, reset case.
// Expectations follow STORE_MISALIGN_SPLIT_EN when it is defined.
module tb_store_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [1:0]  st_type = 2'b00;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        st_done;
  logic        misalign_err;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
    .st_done(st_done), .misalign_err(misalign_err),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    int          dly;
    int          n;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  b0, b1;
  } vec_t;

  vec_t tbl[9];

  int          exp_n;
  logic        exp_err;
  logic [31:0] exp_a[2];
  logic [31:0] exp_d[2];
  logic [3:0]  exp_b[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Byte-by-byte placement: each stored byte lands at address a+k.
  task automatic model(input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d);
    int nb;
    logic [31:0] ba, wa;
    nb = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : (t == 2'd2) ? 4 : 0;
    exp_n = 0;
    exp_err = 1'b0;
    for (int k = 0; k < nb; k++) begin
      ba = a + 32'(k);
      wa = {ba[31:2], 2'b00};
      if (exp_n == 0 || wa != exp_a[exp_n-1]) begin
        exp_a[exp_n] = wa;
        exp_b[exp_n] = 4'b0000;
        exp_d[exp_n] = 32'h0;
        exp_n++;
      end
      exp_b[exp_n-1][ba[1:0]] = 1'b1;
      exp_d[exp_n-1][8*ba[1:0] +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic fix_build();
`ifndef STORE_MISALIGN_SPLIT_EN
    if (exp_n == 2) begin
      exp_n = 0;
      exp_err = 1'b1;
    end
`endif
  endtask

  task automatic run_store(input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] d, input int dly);
    int idx, w, dc, tmo;
    tmo = 0;
    @(negedge clk);
    while (!st_ready && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    if (!st_ready) begin
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    st_valid = 1'b1;
    st_type = t;
    st_addr = a;
    st_data = d;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    st_type = 2'($urandom);
    st_addr = $urandom;
    st_data = $urandom;
    dc = (exp_n == 0) ? 1 : exp_n * (dly + 1) + 1;
    idx = 0;
    w = 0;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      if (idx < exp_n) begin
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, exp_a[idx]);
        chk("mem_be", 32'(mem_be), 32'(exp_b[idx]));
        chk("mem_wdata", mem_wdata, exp_d[idx]);
        if (w < dly) begin
          mem_ack = 1'b0;
          w++;
        end else begin
          mem_ack = 1'b1;
          idx++;
          w = 0;
        end
      end else begin
        chk("mem_req_idle", 32'(mem_req), 32'd0);
        chk("mem_be_idle", 32'(mem_be), 32'd0);
        mem_ack = 1'($urandom);
      end
      chk("st_done", 32'(st_done), 32'(c == dc));
      chk("misalign_err", 32'(misalign_err), 32'(c == dc && exp_err));
      if (c == dc) chk("st_ready_back", 32'(st_ready), 32'd1);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2'd0, 32'h1003, 32'hAABBCCDD, 0, 1,
               32'h1000, 32'h0, 32'hDD000000, 32'h0, 4'b1000, 4'b0000};
    tbl[1] = '{2'd1, 32'h2002, 32'h00001234, 3, 1,
               32'h2000, 32'h0, 32'h12340000, 32'h0, 4'b1100, 4'b0000};
    tbl[2] = '{2'd2, 32'h3001, 32'h11223344, 1, 2,
               32'h3000, 32'h3004, 32'h22334400, 32'h00000011,
               4'b1110, 4'b0001};
    tbl[3] = '{2'd2, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 2,
               32'hFFFFFFFC, 32'h0, 32'hF00D0000, 32'h0000CAFE,
               4'b1100, 4'b0011};
    tbl[4] = '{2'd3, 32'h4001, 32'h55555555, 0, 0,
               32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000};
    tbl[5] = '{2'd2, 32'h5000, 32'hDEADBEEF, 2, 1,
               32'h5000, 32'h0, 32'hDEADBEEF, 32'h0, 4'b1111, 4'b0000};
    tbl[6] = '{2'd1, 32'h6003, 32'hFFFF5678, 0, 2,
               32'h6000, 32'h6004, 32'h78000000, 32'h00000056,
               4'b1000, 4'b0001};
    tbl[7] = '{2'd0, 32'h7000, 32'h123456AB, 0, 1,
               32'h7000, 32'h0, 32'h000000AB, 32'h0, 4'b0001, 4'b0000};
    tbl[8] = '{2'd1, 32'h8001, 32'h0000ABCD, 1, 1,
               32'h8000, 32'h0, 32'h00ABCD00, 32'h0, 4'b0110, 4'b0000};

    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_st_done", 32'(st_done), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    foreach (tbl[i]) begin
      exp_n = tbl[i].n;
      exp_err = 1'b0;
      exp_a[0] = tbl[i].a0;
      exp_a[1] = tbl[i].a1;
      exp_d[0] = tbl[i].d0;
      exp_d[1] = tbl[i].d1;
      exp_b[0] = tbl[i].b0;
      exp_b[1] = tbl[i].b1;
      fix_build();
      run_store(tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].dly);
    end

    for (int r = 0; r < 60; r++) begin
      logic [1:0]  t;
      logic [31:0] a, d;
      t = 2'($urandom);
      a = (r % 8 == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                       : $urandom;
      d = $urandom;
      model(t, a, d);
      fix_build();
      run_store(t, a, d, $urandom_range(0, 3));
    end

    // Abandon a store mid-flight with an asynchronous reset.
    @(negedge clk);
    st_valid = 1'b1;
    st_type = 2'd2;
`ifdef STORE_MISALIGN_SPLIT_EN
    st_addr = 32'h3001;
`else
    st_addr = 32'h5000;
`endif
    st_data = 32'h11223344;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    @(negedge clk);
`ifdef STORE_MISALIGN_SPLIT_EN
    mem_ack = 1'b1;
`endif
    @(negedge clk);
    mem_ack = 1'b0;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
`ifdef STORE_MISALIGN_SPLIT_EN
    chk("pre_rst_hi_addr", mem_addr, 32'h3004);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_be", 32'(mem_be), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_st_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(st_done), 32'd0);
      chk("post_rst_ready", 32'(st_ready), 32'd1);
      chk("post_rst_req", 32'(mem_req), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_ctrl.md
# store_ctrl

Sequences data-memory writes for the core's store path. Accepts one store request at a time (address, data, 2-bit store type), generates word-aligned bus address, shifted write data and byte enables. Drives a request/acknowledge handshake to data memory, splitting a misaligned store into two word transactions when enabled. Sits between the execute-stage store-type decode and the data-memory port.

## Interface
- ADDR_W, 32, byte-address width (≥3)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  controller can accept a request
- st_type  in  2  00 byte, 01 half, 10 word, 11 no store
- st_addr  in  ADDR_W  byte address
- st_data  in  32  store data, right-justified
- st_done  out  1  one-cycle pulse: store fully written (or dropped)
- misalign_err  out  1  one-cycle pulse: misaligned store rejected
- mem_req  out  1  memory write request
- mem_ack  in  1  memory has completed the current write
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 00
- mem_wdata  out  32  lane-positioned write data
- mem_be  out  4  byte enables, bit i = byte lane i

## Operation
- States: IDLE, SEND_LO, SEND_HI.
- st_ready = 1 only in IDLE; acceptance = st_valid & st_ready.
- On acceptance, with o = st_addr[1:0], mask = 0001/0011/1111 for byte/half/word:
  - be8 = {4'b0, mask} << o; d64 = {32'b0, st_data} << (8·o), upper bytes of st_data beyond the type's size zeroed first.
  - Low access: addr {st_addr[ADDR_W-1:2], 00}, be be8[3:0], data d64[31:0].
  - High access (only if be8[7:4] ≠ 0): addr low-word + 4 (modulo 2^ADDR_W, so 0x…FFFC wraps to 0), be be8[7:4], data d64[63:32].
- st_type = 11: accepted, no memory access, st_done pulses next cycle, stays IDLE.
- Aligned or same-word store: IDLE → SEND_LO → (mem_ack) IDLE, st_done pulses with return.
- Split store: IDLE → SEND_LO → (mem_ack) SEND_HI → (mem_ack) IDLE; st_done only after second ack.
- mem_req = 1 exactly in SEND_LO/SEND_HI; mem_addr/mem_wdata/mem_be held stable while mem_req is high and mem_ack low. Outside those states mem_be = 0000.
- mem_ack outside SEND_LO/SEND_HI is ignored.
- Request inputs are captured at acceptance; later changes to st_* do not affect an in-flight store.

## Timing
- Reset values: st_ready 1 after reset release (state IDLE), st_done 0, misalign_err 0, mem_req 0, mem_addr 0, mem_wdata 0, mem_be 0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously); the store in flight is abandoned, no st_done.
- Accept at edge N → mem_req high from cycle N+1. mem_ack sampled high at edge M → mem_req low from M+1 (aligned) or high-half values presented at M+1 (split).
- Minimum aligned store: accept N, ack N+1, st_done and st_ready high in cycle N+2. Minimum split: st_done in N+3.
- st_done, misalign_err are registered single-cycle pulses, coincident with st_ready returning high.

## Configuration
- STORE_MISALIGN_SPLIT_EN defined: misaligned stores (half at o=3, word at o≠0) split as above; misalign_err tied 0.
- Undefined: SEND_HI is never entered; a store with be8[7:4] ≠ 0 is accepted, no memory access occurs, misalign_err and st_done pulse in the next cycle, state stays IDLE. Same-word stores behave identically in both builds.

## Test plan
- Byte store addr 0x1003, data 0xAABBCCDD → one access mem_addr 0x1000, mem_be 1000, mem_wdata 0xDD000000; st_done two cycles after acceptance with ack held high.
- Half store addr 0x2002, data 0x1234 → mem_addr 0x2000, be 1100, wdata 0x12340000; ack delayed 3 cycles → outputs stable throughout, single st_done.
- Word store addr 0x3001, data 0x11223344 (split build) → access 1: 0x3000, be 1110, wdata 0x22334400; access 2: 0x3004, be 0001, wdata 0x00000011; one st_done after second ack. Non-split build → no mem_req, misalign_err and st_done pulse.
- Word store addr 0xFFFFFFFE (split build) → second access mem_addr 0x00000000, be 0011.
- st_type 11 with st_valid → no mem_req, st_done one cycle later; mem_ack pulsed while IDLE ignored.
- rst_n low during SEND_HI → mem_req, mem_be, st_ready-path state cleared immediately; after release st_ready 1, no st_done.
